// File: rtl/ysyx_24120013_pkg.sv
// ysyx_24120013_pkg: shared IFU constants and FSM state encoding
package ysyx_24120013_pkg;
  localparam int INST_WIDTH = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_e;
endpackage

// File: rtl/ysyx_24120013_ifu.sv
// ysyx_24120013_ifu: fetches one word per PC over valid/ready memory, hands inst/pc to IDU, handles redirects
module ysyx_24120013_ifu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(ysyx_24120013_pkg::RESET_PC)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
  input  logic                                   mem_rsp_valid,
  output logic                                   mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]                  mem_rsp_data,
  input  logic                                   mem_rsp_err,
  output logic                                   inst_valid,
  input  logic                                   inst_ready,
  output logic [ysyx_24120013_pkg::INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0]                  inst_pc,
  output logic                                   inst_fault,
  input  logic                                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]                  redirect_pc
);
  import ysyx_24120013_pkg::*;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d, tgt;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic drop_q, drop_d, fault_q, fault_d, req_q, rsp_q, ival_q, req_hs, rsp_hs, kill;
  assign tgt    = redirect_pc & ~ADDR_WIDTH'(3);
  assign req_hs = req_q & mem_req_ready;
  assign rsp_hs = rsp_q & mem_rsp_valid;
  // a response is thrown away if it belongs to a redirected fetch, old or current
  assign kill   = drop_q | redirect_valid;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    case (state_q)
      REQ: begin
        state_d = req_hs ? WAIT : REQ;
        drop_d  = req_hs & redirect_valid;
      end
      WAIT: begin
        state_d = rsp_hs ? (kill ? REQ : HOLD) : WAIT;
        drop_d  = ~rsp_hs & kill;
        if (rsp_hs && !kill) begin
          inst_d    = mem_rsp_data[INST_WIDTH-1:0];
          inst_pc_d = pc_q;
          fault_d   = mem_rsp_err;
          pc_d      = pc_q + ADDR_WIDTH'(4);
        end
      end
      HOLD:    state_d = (inst_ready | redirect_valid) ? REQ : HOLD;
      default: state_d = REQ;
    endcase
    if (redirect_valid) pc_d = tgt;
  end
  // handshake flags are registered from the next state so the reset cycle issues nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
      req_q     <= 1'b0;
      rsp_q     <= 1'b0;
      ival_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
      req_q     <= state_d == REQ;
      rsp_q     <= state_d == WAIT;
      ival_q    <= state_d == HOLD;
    end
  end
  assign mem_req_valid = req_q;
  assign mem_req_addr  = pc_q;
  assign mem_rsp_ready = rsp_q;
  assign inst_valid    = ival_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_fault    = fault_q;
endmodule

// File: tb/tb_ysyx_24120013_ifu.sv
// tb_ysyx_24120013_ifu: directed fetch/redirect/fault/reset scenarios checked against a transaction-level IFU model
module tb_ysyx_24120013_ifu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic        inst_valid, inst_ready, inst_fault, redirect_valid;
  logic [31:0] mem_req_addr, mem_rsp_data, inst, inst_pc, redirect_pc;
  int checks = 0, errors = 0;
  ysyx_24120013_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  // Model: the IFU is either asking for a word, awaiting one (possibly stale), offering one, or just out of reset.
  logic        m_req, m_rsp, m_ival, m_stale, m_flt;
  logic [31:0] m_pc, m_inst, m_ipc, m_tgt;
  assign m_tgt = {redirect_pc[31:2], 2'b00};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req <= 0; m_rsp <= 0; m_ival <= 0; m_stale <= 0; m_flt <= 0;
      m_pc <= 32'h8000_0000; m_inst <= 0; m_ipc <= 0;
    end else if (m_req) begin
      if (mem_req_ready) begin m_req <= 0; m_rsp <= 1; m_stale <= redirect_valid; end
      if (redirect_valid) m_pc <= m_tgt;
    end else if (m_rsp) begin
      if (mem_rsp_valid) begin
        m_rsp <= 0; m_stale <= 0;
        if (m_stale || redirect_valid) m_req <= 1;
        else begin m_ival <= 1; m_inst <= mem_rsp_data; m_ipc <= m_pc; m_flt <= mem_rsp_err; end
        m_pc <= redirect_valid ? m_tgt : (m_stale ? m_pc : m_pc + 32'd4);
      end else if (redirect_valid) begin
        m_stale <= 1; m_pc <= m_tgt;
      end
    end else if (m_ival) begin
      if (redirect_valid || inst_ready) begin m_ival <= 0; m_req <= 1; end
      if (redirect_valid) m_pc <= m_tgt;
    end else begin
      m_req <= 1;
      if (redirect_valid) m_pc <= m_tgt;
    end
  end
  always @(negedge clk) begin
    chk("req_valid", {31'd0, mem_req_valid}, {31'd0, m_req});
    chk("rsp_ready", {31'd0, mem_rsp_ready}, {31'd0, m_rsp});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_ival});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("inst_fault", {31'd0, inst_fault}, {31'd0, m_flt});
    if (m_req) chk("req_addr", mem_req_addr, m_pc);
  end
  task automatic cyc(input logic rq, input logic rv, input logic [31:0] d, input logic e,
                     input logic ir, input logic xv, input logic [31:0] xp);
    mem_req_ready = rq; mem_rsp_valid = rv; mem_rsp_data = d; mem_rsp_err = e;
    inst_ready = ir; redirect_valid = xv; redirect_pc = xp;
    @(negedge clk);
  endtask
  initial begin
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
    chk("rst inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst inst", inst, 32'd0);
    chk("rst inst_pc", inst_pc, 32'd0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("first req", {31'd0, mem_req_valid}, 32'd1);
    chk("first addr", mem_req_addr, 32'h8000_0000);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wait rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);
    cyc(0, 1, 32'h0000_0093, 0, 0, 0, 0);
    chk("first inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("first inst", inst, 32'h0000_0093);
    chk("first inst_pc", inst_pc, 32'h8000_0000);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hold inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("hold no req", {31'd0, mem_req_valid}, 32'd0);
    chk("hold inst", inst, 32'h0000_0093);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("second addr", mem_req_addr, 32'h8000_0004);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h8000_0100);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h1234_5678, 0, 0, 0, 0);
    chk("wait redir no inst", {31'd0, inst_valid}, 32'd0);
    chk("wait redir addr", mem_req_addr, 32'h8000_0100);
    cyc(1, 0, 0, 0, 0, 1, 32'h8000_0203);
    chk("hs redir rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);
    cyc(0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0);
    chk("hs redir addr", mem_req_addr, 32'h8000_0200);
    chk("hs redir no inst", {31'd0, inst_valid}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0010_0073, 0, 0, 0, 0);
    chk("target inst", inst, 32'h0010_0073);
    chk("target inst_pc", inst_pc, 32'h8000_0200);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("fault addr", mem_req_addr, 32'h8000_0204);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    chk("fault flag", {31'd0, inst_fault}, 32'd1);
    chk("fault inst_pc", inst_pc, 32'h8000_0204);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("after fault addr", mem_req_addr, 32'h8000_0208);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0000_0013, 0, 0, 0, 0);
    chk("after fault flag", {31'd0, inst_fault}, 32'd0);
    chk("after fault inst_pc", inst_pc, 32'h8000_0208);
    cyc(0, 0, 0, 0, 1, 1, 32'h8000_0400);
    chk("hold redir drop", {31'd0, inst_valid}, 32'd0);
    chk("hold redir addr", mem_req_addr, 32'h8000_0400);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h1111_1111, 0, 0, 1, 32'h8000_0500);
    chk("same cyc rsp drop", {31'd0, inst_valid}, 32'd0);
    chk("same cyc rsp addr", mem_req_addr, 32'h8000_0500);
    cyc(0, 0, 0, 0, 0, 1, 32'h8000_0600);
    chk("req redir addr", mem_req_addr, 32'h8000_0600);
    cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    chk("align addr", mem_req_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0000_0001, 0, 0, 0, 0);
    chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("wrap addr", mem_req_addr, 32'h0000_0000);
    cyc(1, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_BABE;
    #1;
    chk("async rst rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
    chk("async rst req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("async rst inst_pc", inst_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    cyc(0, 1, 32'hCAFE_BABE, 0, 0, 0, 0);
    chk("rerst addr", mem_req_addr, 32'h8000_0000);
    chk("rerst req_valid", {31'd0, mem_req_valid}, 32'd1);
    cyc(0, 1, 32'hCAFE_BABE, 0, 0, 0, 0);
    chk("late rsp ignored", {31'd0, inst_valid}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0000_0093, 0, 0, 0, 0);
    chk("rerst inst", inst, 32'h0000_0093);
    chk("rerst inst_pc", inst_pc, 32'h8000_0000);
    cyc(0, 0, 0, 0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
